// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the single data-memory port between the data
// cache (D port) and the instruction cache refill path (I port). A granted
// request is captured into registers and held on the memory port until the
// memory acknowledges it. Grants alternate round-robin, and D can lock the
// port so that a writeback and the refill after it run back to back.
module dmem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   d_addr_i,
  input  logic [DATA_WIDTH-1:0]   d_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] d_wstrb_i,
  input  logic                    d_read_i,
  input  logic                    d_write_i,
  input  logic                    d_lock_i,
  output logic [DATA_WIDTH-1:0]   d_rdata_o,
  output logic                    d_ready_o,
  input  logic [ADDR_WIDTH-1:0]   i_addr_i,
  input  logic                    i_read_i,
  output logic [DATA_WIDTH-1:0]   i_rdata_o,
  output logic                    i_ready_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb_o,
  output logic                    mem_read_o,
  output logic                    mem_write_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  input  logic                    mem_ready_i
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic {GRANT_I, GRANT_D} grant_t;

  state_t                state, state_next;
  grant_t                grant_next, grant_id, last_grant;
  logic                  grant_valid;
  logic                  lock_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic [STRB_WIDTH-1:0] wstrb_r;
  logic                  op_r;

  logic d_req, i_req, busy, complete;

  assign d_req    = d_read_i | d_write_i;
  assign i_req    = i_read_i;
  assign busy     = (state == BUSY);
  assign complete = busy & mem_ready_i;

  // Next-state and grant decision; arbitration happens only in IDLE.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_next  = state;
    grant_next  = GRANT_I;
    grant_valid = 1'b0;
    case (state)
      IDLE: begin
        // A held lock forces D whenever D asks; otherwise D wins if I is
        // absent or I had the last grant.
        if (d_req && (lock_r || !i_req || last_grant == GRANT_I)) begin
          grant_next  = GRANT_D;
          grant_valid = 1'b1;
        end else if (i_req) begin
          grant_next  = GRANT_I;
          grant_valid = 1'b1;
        end
        if (grant_valid) state_next = BUSY;
      end
      BUSY: begin
        if (mem_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state always uses non-blocking assignments so every
    // flop samples the pre-edge values regardless of block ordering.
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Capture the winning request so requester inputs are ignored during BUSY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_id <= GRANT_I;
      addr_r   <= '0;
      wdata_r  <= '0;
      wstrb_r  <= '0;
      op_r     <= 1'b0;
    end else if (grant_valid) begin
      grant_id <= grant_next;
      if (grant_next == GRANT_D) begin
        addr_r  <= d_addr_i;
        wdata_r <= d_wdata_i;
        wstrb_r <= d_wstrb_i;
        op_r    <= d_write_i;  // read+write together is treated as a write
      end else begin
        addr_r  <= i_addr_i;
        wdata_r <= '0;
        wstrb_r <= '0;
        op_r    <= 1'b0;
      end
    end
  end

  // Round-robin history and the D lock, updated at completion; a lock with
  // no D request waiting in IDLE is released so I is not starved.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= GRANT_I;
      lock_r     <= 1'b0;
    end else if (complete) begin
      last_grant <= grant_id;
      lock_r     <= d_lock_i && (grant_id == GRANT_D);
    end else if (!busy && lock_r && !d_req) begin
      lock_r     <= 1'b0;
    end
  end

  // Memory port is driven only in BUSY, so reset clears it immediately.
  assign mem_addr_o  = busy ? addr_r  : '0;
  assign mem_wdata_o = busy ? wdata_r : '0;
  assign mem_wstrb_o = busy ? wstrb_r : '0;
  assign mem_read_o  = busy & ~op_r;
  assign mem_write_o = busy &  op_r;

  // Completion is routed combinationally to the granted port only.
  assign d_ready_o = complete && (grant_id == GRANT_D);
  assign i_ready_o = complete && (grant_id == GRANT_I);
  assign d_rdata_o = d_ready_o ? mem_rdata_i : '0;
  assign i_rdata_o = i_ready_o ? mem_rdata_i : '0;

endmodule
